// File: rtl/alu_op_controller.sv
// alu_op_controller: sequences a 16-bit ALU and register file.
// Each instruction is accepted in IDLE and steps through READ -> EXEC -> WRITE.
// A registered Done pulse retires NOPs, a sticky flag records illegal opcodes,
// and HALT parks the controller until reset.
// Optional feature: define STATUS_FLAGS_EN to add the AluResult input and the Zero/Neg
// status outputs, which are captured at the end of WRITE.
module alu_op_controller #(
    parameter int unsigned ADDR_W  = 4,
    parameter int unsigned INSTR_W = 16
) (
    input  logic               Clk,
    input  logic               ResetN,
    input  logic               InstrValid,
    input  logic [INSTR_W-1:0] Instr,
`ifdef STATUS_FLAGS_EN
    input  logic [15:0]        AluResult,
    output logic               Zero,
    output logic               Neg,
`endif
    output logic               InstrReady,
    output logic [ADDR_W-1:0]  RF_Ra_Addr,
    output logic [ADDR_W-1:0]  RF_Rb_Addr,
    output logic               RF_Ra_Rd,
    output logic               RF_Rb_Rd,
    output logic [ADDR_W-1:0]  RF_W_Addr,
    output logic               RF_W_En,
    output logic [2:0]         ALU_Sel,
    output logic               Done,
    output logic               Halted,
    output logic               IllegalOp
);

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StExec,
        StWrite,
        StHalt
    } state_e;

    state_e state_q, state_d;

    // Latched instruction fields
    logic [3:0]        opcode_q, opcode_d;
    logic [ADDR_W-1:0] ra_q, ra_d;
    logic [ADDR_W-1:0] rb_q, rb_d;
    logic [ADDR_W-1:0] rd_q, rd_d;

    // NOP retirement pulse and sticky illegal flag
    logic done_q, done_d;
    logic illegal_q, illegal_d;

    // Decode of the incoming opcode
    logic [3:0] in_opcode;
    logic       in_nop;
    logic       in_alu;
    logic       in_halt;
    logic       in_illegal;
    logic       accept;
    logic       op_unary;

    assign in_opcode = Instr[15:12];
    assign accept    = InstrValid && (state_q == StIdle);

    // Classify the incoming opcode into NOP / ALU / HALT / illegal
    always_comb begin
        in_nop     = 1'b0;
        in_alu     = 1'b0;
        in_halt    = 1'b0;
        in_illegal = 1'b0;
        if (in_opcode == 4'h0) begin
            in_nop = 1'b1;
        end else if (in_opcode[3] == 1'b0) begin
            in_alu = 1'b1;
        end else if (in_opcode == 4'hF) begin
            in_halt = 1'b1;
        end else begin
            in_illegal = 1'b1;
        end
    end

    // Pass A (3) and increment (7) only consume operand A
    assign op_unary = (opcode_q[1:0] == 2'b11);

    // Next-state, field latching and status updates
    always_comb begin
        state_d   = state_q;
        opcode_d  = opcode_q;
        ra_d      = ra_q;
        rb_d      = rb_q;
        rd_d      = rd_q;
        done_d    = 1'b0;
        illegal_d = illegal_q;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    opcode_d = in_opcode;
                    ra_d     = Instr[8 +: ADDR_W];
                    rb_d     = Instr[4 +: ADDR_W];
                    rd_d     = Instr[0 +: ADDR_W];
                    if (in_alu) begin
                        state_d = StRead;
                    end else if (in_nop) begin
                        done_d = 1'b1;
                    end else if (in_halt) begin
                        state_d = StHalt;
                    end else if (in_illegal) begin
                        illegal_d = 1'b1;
                    end
                end
            end
            StRead:  state_d = StExec;
            StExec:  state_d = StWrite;
            StWrite: state_d = StIdle;
            StHalt:  state_d = StHalt;
            default: state_d = StIdle;
        endcase
    end

    // State, latched instruction and status registers
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            state_q   <= StIdle;
            opcode_q  <= 4'h0;
            ra_q      <= '0;
            rb_q      <= '0;
            rd_q      <= '0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            opcode_q  <= opcode_d;
            ra_q      <= ra_d;
            rb_q      <= rb_d;
            rd_q      <= rd_d;
            done_q    <= done_d;
            illegal_q <= illegal_d;
        end
    end

    // Datapath control outputs decoded from the current state
    always_comb begin
        RF_Ra_Rd = 1'b0;
        RF_Rb_Rd = 1'b0;
        RF_W_En  = 1'b0;
        ALU_Sel  = 3'd0;
        unique case (state_q)
            StRead: begin
                RF_Ra_Rd = 1'b1;
                RF_Rb_Rd = !op_unary;
                ALU_Sel  = opcode_q[2:0];
            end
            StExec: begin
                ALU_Sel = opcode_q[2:0];
            end
            StWrite: begin
                RF_W_En = 1'b1;
                ALU_Sel = opcode_q[2:0];
            end
            default: begin
                ALU_Sel = 3'd0;
            end
        endcase
    end

    // Ready is held low while reset is asserted so all outputs read 0 in reset
    assign InstrReady = (state_q == StIdle) && ResetN;
    assign RF_Ra_Addr = ra_q;
    assign RF_Rb_Addr = rb_q;
    assign RF_W_Addr  = rd_q;
    assign Done       = done_q || (state_q == StWrite);
    assign Halted     = (state_q == StHalt);
    assign IllegalOp  = illegal_q;

`ifdef STATUS_FLAGS_EN
    logic zero_q, neg_q;

    // Capture result flags on the edge that leaves WRITE
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
        end else if (state_q == StWrite) begin
            zero_q <= (AluResult == 16'h0000);
            neg_q  <= AluResult[15];
        end
    end

    assign Zero = zero_q;
    assign Neg  = neg_q;
`endif

endmodule
